// File: rtl/median_seq_pkg.sv
// -----------------------------------------------------------------------------
// median_seq_pkg
// Shared types and constants for the median-filter frame sequencer.
//   seq_state_e  : frame-level FSM states
//   DEF_IMG_W/H  : default image geometry
//   DEF_CNT_W    : default width of the active-window count and threshold
//   ADDR_W       : image-memory row/column address width
//   FRAME_CNT_W  : width of the wrapping completed-frame counter
// -----------------------------------------------------------------------------
package median_seq_pkg;

  localparam int DEF_IMG_W   = 80;
  localparam int DEF_IMG_H   = 60;
  localparam int DEF_CNT_W   = 13;
  localparam int ADDR_W      = 8;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    FILTER,
    EVAL
  } seq_state_e;

endpackage

// File: rtl/raster_addr_counter.sv
// -----------------------------------------------------------------------------
// raster_addr_counter
// Column/row counter that walks an IMG_W x IMG_H image in raster order.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : force both counters to (0,0); wins over inc_i
//   inc_i      : advance one pixel; wraps to (0,0) after the last pixel
//   x_o, y_o   : current column / row
//   last_o     : current position is the final pixel (IMG_W-1, IMG_H-1)
// -----------------------------------------------------------------------------
module raster_addr_counter
  import median_seq_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] x_o,
  output logic [ADDR_W-1:0] y_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);

  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;

  always_comb begin
    // NOTE: next-state defaults to the held value so every path assigns and no latch is inferred.
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        // Wrapping y at the last row leaves the counter at (0,0) for the next frame.
        y_d = (y_q == Y_LAST) ? '0 : y_q + ADDR_W'(1);
      end else begin
        x_d = x_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments; reset is sampled on the clock edge only.
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/median_frame_sequencer.sv
// -----------------------------------------------------------------------------
// median_frame_sequencer
// Frame-level controller for the binary median-filter datapath. Loads one
// raster frame into image memory, pulses the median reader's start, waits for
// its completion and compares the active-window count with the threshold to
// drive the wake-up flag.
//
// Optional feature: define WAKE_STICKY_EN to make wakeUp sticky (set by a hit,
// cleared by wakeAck, set wins). Default build: wakeUp follows each frame's hit
// and wakeAck is ignored.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   enable              : run frames back to back while high
//   pixValid/pixData    : incoming pixel stream; pixReady accepts in LOAD
//   memWrite/memXAddr/memYAddr/memData : image-memory write port
//   filterStart         : one-cycle start pulse to the median reader
//   filterDone          : reader full-image-done level
//   activeWindows       : reader result count
//   threshold           : wake threshold (strict greater-than)
//   wakeAck             : clears a sticky wake request
//   wakeUp              : wake request
//   busy                : sequencer not idle
//   frameCount          : completed frames, wrapping
// -----------------------------------------------------------------------------
module median_frame_sequencer
  import median_seq_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   pixValid,
  input  logic                   pixData,
  output logic                   pixReady,
  output logic                   memWrite,
  output logic [ADDR_W-1:0]      memXAddr,
  output logic [ADDR_W-1:0]      memYAddr,
  output logic                   memData,
  output logic                   filterStart,
  input  logic                   filterDone,
  input  logic [CNT_W-1:0]       activeWindows,
  input  logic [CNT_W-1:0]       threshold,
  input  logic                   wakeAck,
  output logic                   wakeUp,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frameCount
);

  seq_state_e              state_q;
  logic                    wake_q;
  logic [FRAME_CNT_W-1:0]  frame_cnt_q;

  logic [ADDR_W-1:0]       x_cnt;
  logic [ADDR_W-1:0]       y_cnt;
  logic                    last_pix;
  logic                    xfer;
  logic                    hit;

  // A transfer is the pixel handshake; it doubles as the zero-latency memory write.
  assign xfer = (state_q == LOAD) && pixValid;
  assign hit  = activeWindows > threshold;

  raster_addr_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_addr_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q == IDLE),
    .inc_i   (xfer),
    .x_o     (x_cnt),
    .y_o     (y_cnt),
    .last_o  (last_pix)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wake_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE:   if (enable) state_q <= LOAD;
        LOAD:   if (xfer && last_pix) state_q <= START;
        // filterDone is not looked at in START, so a level left over from the
        // previous frame cannot end FILTER before the reader restarts.
        START:  state_q <= FILTER;
        FILTER: if (filterDone) state_q <= EVAL;
        EVAL: begin
          frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
          state_q     <= enable ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase

`ifdef WAKE_STICKY_EN
      if ((state_q == EVAL) && hit) begin
        wake_q <= 1'b1;
      end else if (wakeAck) begin
        wake_q <= 1'b0;
      end
`else
      if (state_q == EVAL) begin
        wake_q <= hit;
      end
`endif
    end
  end

`ifndef WAKE_STICKY_EN
  logic wake_ack_unused;
  assign wake_ack_unused = wakeAck;
`endif

  assign pixReady    = (state_q == LOAD);
  assign memWrite    = xfer;
  assign memXAddr    = x_cnt;
  assign memYAddr    = y_cnt;
  assign memData     = pixData;
  assign filterStart = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign wakeUp      = wake_q;
  assign frameCount  = frame_cnt_q;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_median_frame_sequencer
// Directed bench for a 4x3 image. Stimulus tasks push the expected memory
// writes and start pulses into a scoreboard queue; an independent monitor
// compares them against what the sequencer presents. Frame-level results
// (wakeUp, frameCount, busy, pixReady) are checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_median_frame_sequencer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int CNT_W = 13;
  localparam int NPIX  = IMG_W * IMG_H;

`ifdef WAKE_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             pixValid;
  logic             pixData;
  logic             pixReady;
  logic             memWrite;
  logic [7:0]       memXAddr;
  logic [7:0]       memYAddr;
  logic             memData;
  logic             filterStart;
  logic             filterDone;
  logic [CNT_W-1:0] activeWindows;
  logic [CNT_W-1:0] threshold;
  logic             wakeAck;
  logic             wakeUp;
  logic             busy;
  logic [15:0]      frameCount;

  median_frame_sequencer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pixValid      (pixValid),
    .pixData       (pixData),
    .pixReady      (pixReady),
    .memWrite      (memWrite),
    .memXAddr      (memXAddr),
    .memYAddr      (memYAddr),
    .memData       (memData),
    .filterStart   (filterStart),
    .filterDone    (filterDone),
    .activeWindows (activeWindows),
    .threshold     (threshold),
    .wakeAck       (wakeAck),
    .wakeUp        (wakeUp),
    .busy          (busy),
    .frameCount    (frameCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_start;
    logic [7:0] x;
    logic [7:0] y;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic pix_val(input int n, input bit inv);
    int x;
    int y;
    x = n % IMG_W;
    y = n / IMG_W;
    return logic'((x ^ y) & 1) ^ inv;
  endfunction

  // Monitor: every write or start the DUT presents must match the next expected item.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (memWrite) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = sb.pop_front();
          check("write_kind", 32'(e.is_start), 0);
          check("write_x", memXAddr, e.x);
          check("write_y", memYAddr, e.y);
          check("write_data", memData, e.d);
        end
      end
      if (filterStart) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          e = sb.pop_front();
          check("start_kind", 32'(e.is_start), 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_write(input int n, input bit inv);
    exp_t e;
    e.is_start = 1'b0;
    e.x        = 8'(n % IMG_W);
    e.y        = 8'(n / IMG_W);
    e.d        = pix_val(n, inv);
    sb.push_back(e);
  endtask

  // Offer pixels until count have been accepted; optionally gap pixValid.
  task automatic load_frame(input int count, input bit toggle, input bit inv);
    exp_t e;
    int   n = 0;
    int   guard = 0;
    bit   hs;
    for (int i = 0; i < count; i++) push_write(i, inv);
    if (count == NPIX) begin
      e.is_start = 1'b1;
      e.x = '0;
      e.y = '0;
      e.d = 1'b0;
      sb.push_back(e);
    end
    while (n < count && guard < 200) begin
      pixValid = toggle ? ~guard[0] : 1'b1;
      pixData  = pix_val(n, inv);
      hs       = pixValid && pixReady;
      tick();
      if (hs) n++;
      guard++;
    end
    pixValid = 1'b0;
    if (n < count) check("load_timeout", n, count);
  endtask

  // Called in the START cycle; walks FILTER and EVAL with a fixed reader latency.
  task automatic finish_frame(input int aw, input int th, input bit early,
                              input bit drop_en, input bit ack_at_eval,
                              input bit exp_wake, input int exp_fc);
    activeWindows = CNT_W'(aw);
    threshold     = CNT_W'(th);
    check("ready_after_load", pixReady, 0);
    check("busy_in_start", busy, 1);
    tick();  // FILTER
    if (drop_en) enable = 1'b0;
    if (!early) begin
      repeat (2) tick();
      filterDone = 1'b1;
    end
    check("no_early_eval", frameCount, 32'(exp_fc - 1));
    tick();  // EVAL
    check("count_before_eval_end", frameCount, 32'(exp_fc - 1));
    if (ack_at_eval) wakeAck = 1'b1;
    filterDone = 1'b0;
    tick();  // results visible
    check("frame_count", frameCount, 32'(exp_fc));
    check("wake_up", wakeUp, 32'(exp_wake));
    wakeAck = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pixReady"}, pixReady, 0);
    check({tag, "_memWrite"}, memWrite, 0);
    check({tag, "_memXAddr"}, memXAddr, 0);
    check({tag, "_memYAddr"}, memYAddr, 0);
    check({tag, "_filterStart"}, filterStart, 0);
    check({tag, "_wakeUp"}, wakeUp, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frameCount"}, frameCount, 0);
  endtask

  initial begin : stimulus
    reset         = 1'b1;
    enable        = 1'b0;
    pixValid      = 1'b0;
    pixData       = 1'b0;
    filterDone    = 1'b0;
    activeWindows = '0;
    threshold     = '0;
    wakeAck       = 1'b0;
    repeat (2) tick();
    check_reset_values("reset");
    reset = 1'b0;

    // F1: continuous pixels, filterDone already high before START, equal counts -> no hit.
    enable     = 1'b1;
    filterDone = 1'b1;
    load_frame(NPIX, 1'b0, 1'b0);
    finish_frame(100, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // F2: gapped pixels, inverted pattern, 101 > 100 -> hit.
    load_frame(NPIX, 1'b1, 1'b1);
    finish_frame(101, 100, 1'b0, 1'b0, 1'b0, 1'b1, 2);

    // F3: no hit; sticky wake holds, plain wake clears.
    load_frame(NPIX, 1'b0, 1'b0);
    finish_frame(0, 0, 1'b0, 1'b0, 1'b0, STICKY, 3);

    // Ack pulse clears a sticky wake; plain wake is already 0.
    wakeAck = 1'b1;
    tick();
    wakeAck = 1'b0;
    check("wake_after_ack", wakeUp, 0);

    // F4: hit with wakeAck high during EVAL -> set wins.
    load_frame(NPIX, 1'b0, 1'b1);
    finish_frame(8191, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4);

    // F5: enable dropped in FILTER, no hit -> frame completes, then idle.
    load_frame(NPIX, 1'b1, 1'b0);
    finish_frame(1, 2, 1'b0, 1'b1, 1'b0, STICKY, 5);
    pixValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("idle_busy", busy, 0);
      check("idle_pixReady", pixReady, 0);
      tick();
    end
    pixValid = 1'b0;

    // F6: reset while the 6th pixel is being written.
    enable = 1'b1;
    load_frame(5, 1'b0, 1'b0);
    push_write(5, 1'b0);
    pixValid = 1'b1;
    pixData  = pix_val(5, 1'b0);
    reset    = 1'b1;
    tick();
    check_reset_values("midreset");
    reset    = 1'b0;
    pixValid = 1'b0;

    // F7: fresh frame after reset restarts at (0,0).
    load_frame(NPIX, 1'b0, 1'b0);
    finish_frame(1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    repeat (2) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
